// File: rtl/qkt_mh_pkg.sv
// Shared types for the multi-head QK^T sequencer: FSM states, error codes and the FP32 -inf mask value.
package qkt_mh_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHK,
    ST_TR_KICK,
    ST_TR_WAIT,
    ST_CP_RD,
    ST_CP_WAIT,
    ST_GEMM_KICK,
    ST_GEMM_WAIT,
    ST_HNEXT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_CFG   = 2'd1,
    ERR_TMO   = 2'd2,
    ERR_ABORT = 2'd3
  } err_e;

  localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;

endpackage

// File: rtl/qkt_causal_mask.sv
// Score read path: aligns tq/tk/mask with core_rvalid, then registers the (optionally -inf masked) score.
// Latency RD_LAT+1 from score_re to score_rvalid; no backpressure, one result per request.
module qkt_causal_mask
  import qkt_mh_pkg::*;
#(
  parameter int T      = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int T_W    = (T <= 1) ? 1 : $clog2(T)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              causal_en,
  input  logic              score_re,
  input  logic [T_W-1:0]    score_tq,
  input  logic [T_W-1:0]    score_tk,
  input  logic [DATA_W-1:0] core_rdata,
  input  logic              core_rvalid,
  output logic [DATA_W-1:0] score_rdata,
  output logic              score_rvalid
);

  logic [T_W-1:0] tq_sr [RD_LAT];
  logic [T_W-1:0] tk_sr [RD_LAT];
  logic           m_sr  [RD_LAT];
  logic           mask_out;

  // Fixed-latency delay line: entry RD_LAT-1 belongs to the word on core_rdata this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tq_sr[i] <= '0;
        tk_sr[i] <= '0;
        m_sr[i]  <= 1'b0;
      end
    end else begin
      tq_sr[0] <= score_tq;
      tk_sr[0] <= score_tk;
      m_sr[0]  <= causal_en & score_re;
      for (int i = 1; i < RD_LAT; i++) begin
        tq_sr[i] <= tq_sr[i-1];
        tk_sr[i] <= tk_sr[i-1];
        m_sr[i]  <= m_sr[i-1];
      end
    end
  end

  assign mask_out = m_sr[RD_LAT-1] && (tk_sr[RD_LAT-1] > tq_sr[RD_LAT-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_rvalid <= 1'b0;
      score_rdata  <= '0;
    end else begin
      score_rvalid <= core_rvalid;
      if (!core_rvalid)
        score_rdata <= '0;
      else if (mask_out)
        score_rdata <= DATA_W'(FP32_NEG_INF);
      else
        score_rdata <= core_rdata;
    end
  end

endmodule

// File: rtl/qkt_mh_sched.sv
// Multi-head QK^T sequencer: per head kick transpose, copy K^T into GEMM X SRAM, run GEMM; watchdog/abort.
// One K^T read outstanding at a time; waits on tr_done/gemm_done; score reads pass through with RD_LAT+1 latency.
module qkt_mh_sched
  import qkt_mh_pkg::*;
#(
  parameter  int T      = 8,
  parameter  int DMAX   = 1024,
  parameter  int DATA_W = 32,
  parameter  int HMAX   = 8,
  parameter  int RD_LAT = 1,
  parameter  int TMO    = 4096,
  localparam int BYTE_W = DATA_W / 8,
  localparam int H_W    = (HMAX <= 1) ? 1 : $clog2(HMAX),
  localparam int T_W    = (T <= 1) ? 1 : $clog2(T),
  localparam int D_W    = (DMAX <= 1) ? 1 : $clog2(DMAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       D_len,
  input  logic [H_W:0]      n_heads,
  input  logic              causal_en,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [H_W-1:0]    head_sel,
  output logic              tr_start,
  input  logic              tr_busy,
  input  logic              tr_done,
  output logic              tr_b_re,
  output logic [31:0]       tr_b_row,
  output logic [31:0]       tr_b_col,
  input  logic [DATA_W-1:0] tr_b_rdata,
  input  logic              tr_b_rvalid,
  output logic              cpu_x_we,
  output logic [D_W-1:0]    cpu_x_k,
  output logic [T_W-1:0]    cpu_x_n,
  output logic [DATA_W-1:0] cpu_x_wdata,
  output logic [BYTE_W-1:0] cpu_x_wmask,
  output logic              gemm_start,
  input  logic              gemm_busy,
  input  logic              gemm_done,
  input  logic              C_valid,
  input  logic              score_re,
  input  logic [T_W-1:0]    score_tq,
  input  logic [T_W-1:0]    score_tk,
  output logic              core_re,
  output logic [T_W-1:0]    core_tq,
  output logic [T_W-1:0]    core_tk,
  input  logic [DATA_W-1:0] core_rdata,
  input  logic              core_rvalid,
  output logic [DATA_W-1:0] score_rdata,
  output logic              score_rvalid
);

  localparam int          WD_W   = $clog2(TMO + 1);
  localparam logic [31:0] DMAX_L = 32'(DMAX);
  localparam logic [31:0] HMAX_L = 32'(HMAX);

  state_e          state_q, state_d;
  err_e            err_q, err_d;
  logic [15:0]     d_len_q;
  logic [H_W:0]    n_heads_q;
  logic            causal_q;
  logic [H_W-1:0]  head_q;
  logic [15:0]     d_q;
  logic [T_W-1:0]  n_q;
  logic [WD_W-1:0] wd_q;

  logic cfg_bad, last_n, last_d, wd_exp, head_more, in_wait, wr_fire;
  logic unused_in;

  // Status inputs are not needed: the done pulses alone sequence the run.
  assign unused_in = ^{tr_busy, gemm_busy, C_valid};

  assign cfg_bad   = (d_len_q == 16'd0) || (32'(d_len_q) > DMAX_L) ||
                     (n_heads_q == '0)  || (32'(n_heads_q) > HMAX_L);
  assign last_n    = (n_q == T_W'(T - 1));
  assign last_d    = (d_q == d_len_q - 16'd1);
  assign wd_exp    = (wd_q == WD_W'(TMO - 1));
  assign head_more = (({1'b0, head_q} + (H_W+1)'(1)) < n_heads_q);
  assign in_wait   = (state_q == ST_TR_WAIT) || (state_q == ST_CP_WAIT) ||
                     (state_q == ST_GEMM_WAIT);
  assign wr_fire   = (state_q == ST_CP_WAIT) && tr_b_rvalid && !abort;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_CHK;
        err_d   = ERR_NONE;
      end
      ST_CHK: begin
        if (cfg_bad) begin
          state_d = ST_DONE;
          err_d   = ERR_CFG;
        end else begin
          state_d = ST_TR_KICK;
        end
      end
      ST_TR_KICK: state_d = ST_TR_WAIT;
      ST_TR_WAIT: begin
        if (tr_done) begin
          state_d = ST_CP_RD;
        end else if (wd_exp) begin
          state_d = ST_DONE;
          err_d   = ERR_TMO;
        end
      end
      ST_CP_RD: state_d = ST_CP_WAIT;
      ST_CP_WAIT: begin
        if (tr_b_rvalid) begin
          state_d = (last_n && last_d) ? ST_GEMM_KICK : ST_CP_RD;
        end else if (wd_exp) begin
          state_d = ST_DONE;
          err_d   = ERR_TMO;
        end
      end
      ST_GEMM_KICK: state_d = ST_GEMM_WAIT;
      ST_GEMM_WAIT: begin
        if (gemm_done) begin
          state_d = ST_HNEXT;
        end else if (wd_exp) begin
          state_d = ST_DONE;
          err_d   = ERR_TMO;
        end
      end
      ST_HNEXT: state_d = head_more ? ST_TR_KICK : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Abort overrides any completion or data event seen in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      err_d   = ERR_ABORT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      err_q     <= ERR_NONE;
      d_len_q   <= '0;
      n_heads_q <= '0;
      causal_q  <= 1'b0;
      head_q    <= '0;
      d_q       <= '0;
      n_q       <= '0;
      wd_q      <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if ((state_q == ST_IDLE) && start) begin
        d_len_q   <= D_len;
        n_heads_q <= n_heads;
        causal_q  <= causal_en;
        head_q    <= '0;
      end
      if (state_q == ST_TR_KICK) begin
        d_q <= '0;
        n_q <= '0;
      end else if (wr_fire) begin
        if (last_n) begin
          n_q <= '0;
          d_q <= d_q + 16'd1;
        end else begin
          n_q <= n_q + T_W'(1);
        end
      end
      if ((state_q == ST_HNEXT) && head_more && !abort)
        head_q <= head_q + H_W'(1);
      if (state_d != state_q)
        wd_q <= '0;
      else if (in_wait)
        wd_q <= wd_q + WD_W'(1);
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE) && !abort;
  assign err_code    = err_q;
  assign head_sel    = head_q;
  assign tr_start    = (state_q == ST_TR_KICK) && !abort;
  assign gemm_start  = (state_q == ST_GEMM_KICK) && !abort;
  assign tr_b_re     = (state_q == ST_CP_RD) && !abort;
  assign tr_b_row    = tr_b_re ? 32'(d_q) : 32'd0;
  assign tr_b_col    = tr_b_re ? 32'(n_q) : 32'd0;
  assign cpu_x_we    = wr_fire;
  assign cpu_x_k     = wr_fire ? d_q[D_W-1:0] : '0;
  assign cpu_x_n     = wr_fire ? n_q : '0;
  assign cpu_x_wdata = wr_fire ? tr_b_rdata : '0;
  assign cpu_x_wmask = wr_fire ? '1 : '0;

  assign core_re = score_re;
  assign core_tq = score_tq;
  assign core_tk = score_tk;

  qkt_causal_mask #(
    .T      (T),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .T_W    (T_W)
  ) u_mask (
    .clk          (clk),
    .rst_n        (rst_n),
    .causal_en    (causal_q),
    .score_re     (score_re),
    .score_tq     (score_tq),
    .score_tk     (score_tk),
    .core_rdata   (core_rdata),
    .core_rvalid  (core_rvalid),
    .score_rdata  (score_rdata),
    .score_rvalid (score_rvalid)
  );

endmodule

// File: tb/tb_qkt_mh_sched.sv
// Directed bench for qkt_mh_sched with a responsive core model and scoreboards for X writes and score reads.
module tb_qkt_mh_sched;

  localparam int T = 4, DMAX = 1024, DATA_W = 32, HMAX = 8, RD_LAT = 1, TMO = 64;
  localparam int H_W = 3, T_W = 2, D_W = 10, BYTE_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, causal_en = 1'b0, abort = 1'b0;
  logic [15:0] D_len = '0;
  logic [H_W:0] n_heads = '0;
  logic busy, done, tr_start, tr_b_re, cpu_x_we, gemm_start, core_re, score_rvalid;
  logic [1:0] err_code;
  logic [H_W-1:0] head_sel;
  logic [31:0] tr_b_row, tr_b_col;
  logic [D_W-1:0] cpu_x_k;
  logic [T_W-1:0] cpu_x_n, core_tq, core_tk;
  logic [DATA_W-1:0] cpu_x_wdata, score_rdata;
  logic [BYTE_W-1:0] cpu_x_wmask;
  logic tr_busy = 1'b0, gemm_busy = 1'b0, C_valid = 1'b0;
  logic tr_done = 1'b0, tr_b_rvalid = 1'b0, gemm_done = 1'b0, core_rvalid = 1'b0;
  logic [DATA_W-1:0] tr_b_rdata = '0, core_rdata = '0;
  logic score_re = 1'b0;
  logic [T_W-1:0] score_tq = '0, score_tk = '0;
  logic gemm_hold = 1'b0;

  qkt_mh_sched #(.T(T), .DMAX(DMAX), .DATA_W(DATA_W), .HMAX(HMAX), .RD_LAT(RD_LAT), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .D_len(D_len), .n_heads(n_heads),
    .causal_en(causal_en), .abort(abort), .busy(busy), .done(done), .err_code(err_code),
    .head_sel(head_sel), .tr_start(tr_start), .tr_busy(tr_busy), .tr_done(tr_done),
    .tr_b_re(tr_b_re), .tr_b_row(tr_b_row), .tr_b_col(tr_b_col), .tr_b_rdata(tr_b_rdata),
    .tr_b_rvalid(tr_b_rvalid), .cpu_x_we(cpu_x_we), .cpu_x_k(cpu_x_k), .cpu_x_n(cpu_x_n),
    .cpu_x_wdata(cpu_x_wdata), .cpu_x_wmask(cpu_x_wmask), .gemm_start(gemm_start),
    .gemm_busy(gemm_busy), .gemm_done(gemm_done), .C_valid(C_valid), .score_re(score_re),
    .score_tq(score_tq), .score_tk(score_tk), .core_re(core_re), .core_tq(core_tq),
    .core_tk(core_tk), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .score_rdata(score_rdata), .score_rvalid(score_rvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: transpose/GEMM finish one cycle after their kick, reads return after one cycle.
  always @(posedge clk) begin
    tr_done     <= tr_start;
    tr_b_rvalid <= tr_b_re;
    tr_b_rdata  <= (32'(head_sel) << 24) | (tr_b_row << 8) | tr_b_col;
    gemm_done   <= gemm_start & ~gemm_hold;
    core_rvalid <= core_re;
    core_rdata  <= 32'hC000_0000 | (32'(core_tq) << 4) | 32'(core_tk);
  end

  typedef struct { logic [31:0] data; int cyc; } sexp_t;
  logic [63:0] wq[$];
  sexp_t sq[$];
  logic [H_W-1:0] gs_head[$];
  int errors = 0, checks = 0;
  int n_tr = 0, n_done = 0, n_wr = 0, gs_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int k, input int n, input logic [31:0] data);
    return {16'd0, 10'(k), 2'(n), 4'hF, data};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (tr_start) n_tr++;
      if (done) n_done++;
      if (gemm_start) begin
        gs_head.push_back(head_sel);
        gs_cyc = cyc;
      end
      if (cpu_x_we) begin
        n_wr++;
        checks++;
        assert (wq.size() > 0) else begin
          errors++;
          $error("FAIL x_write_unexpected: observed=%0h expected=none", cpu_x_wdata);
        end
        if (wq.size() > 0)
          chk("x_write", {16'd0, cpu_x_k, cpu_x_n, cpu_x_wmask, cpu_x_wdata}, wq.pop_front());
      end
      if (score_rvalid) begin
        checks++;
        assert (sq.size() > 0) else begin
          errors++;
          $error("FAIL score_unexpected: observed=%0h expected=none", score_rdata);
        end
        if (sq.size() > 0) begin
          sexp_t e;
          e = sq.pop_front();
          chk("score_data", 64'(score_rdata), 64'(e.data));
          chk("score_latency", 64'(cyc - e.cyc), 64'(RD_LAT + 1));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int d, input int nh, input logic c);
    D_len = 16'(d); n_heads = (H_W+1)'(nh); causal_en = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_writes(input int h, input int dl);
    for (int d = 0; d < dl; d++)
      for (int n = 0; n < T; n++)
        wq.push_back(pk(d, n, (32'(h) << 24) | (32'(d) << 8) | 32'(n)));
  endtask

  task automatic rd(input int tq, input int tk, input logic [31:0] exp_data);
    score_tq = T_W'(tq); score_tk = T_W'(tk); score_re = 1'b1;
    sq.push_back('{exp_data, cyc});
    tick();
    score_re = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int used, output bit seen);
    seen = 1'b0; used = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1; used = i + 1;
        break;
      end
    end
  endtask

  int base_tr, base_gs, base_wr, base_done, used;
  bit seen;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_code), 64'd0);
    chk("rst_head", 64'(head_sel), 64'd0);
    chk("rst_kicks", 64'({tr_start, gemm_start, tr_b_re, cpu_x_we}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Two heads, D_len=3; a second start mid-run must be ignored
    base_tr = n_tr; base_gs = gs_head.size(); base_wr = n_wr; base_done = n_done;
    push_writes(0, 3); push_writes(1, 3);
    do_start(3, 2, 1'b0);
    chk("t1_busy", 64'(busy), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tr_start) begin seen = 1'b1; break; end
    end
    chk("t1_tr_start_seen", 64'(seen), 64'd1);
    tick();
    do_start(0, 0, 1'b0);
    wait_done(2000, used, seen);
    chk("t1_done_seen", 64'(seen), 64'd1);
    chk("t1_err", 64'(err_code), 64'd0);
    tick();
    chk("t1_busy_low", 64'(busy), 64'd0);
    chk("t1_tr_starts", 64'(n_tr - base_tr), 64'd2);
    chk("t1_gemm_starts", 64'(gs_head.size() - base_gs), 64'd2);
    chk("t1_writes", 64'(n_wr - base_wr), 64'd24);
    chk("t1_wq_empty", 64'(wq.size()), 64'd0);
    chk("t1_done_count", 64'(n_done - base_done), 64'd1);
    if (gs_head.size() >= 2) begin
      chk("t1_head0", 64'(gs_head[0]), 64'd0);
      chk("t1_head1", 64'(gs_head[1]), 64'd1);
    end
    chk("t1_head_hold", 64'(head_sel), 64'd1);

    // Score reads without causal masking
    rd(1, 2, 32'hC000_0012);
    rd(2, 1, 32'hC000_0021);
    tick(); tick();

    // Configuration errors
    base_tr = n_tr; base_gs = gs_head.size();
    do_start(0, 2, 1'b1);
    wait_done(3, used, seen);
    chk("t2_dlen0_done", 64'(seen), 64'd1);
    chk("t2_dlen0_err", 64'(err_code), 64'd1);
    tick();
    do_start(3, 0, 1'b1);
    wait_done(3, used, seen);
    chk("t2_nh0_done", 64'(seen), 64'd1);
    chk("t2_nh0_err", 64'(err_code), 64'd1);
    tick();
    do_start(DMAX + 1, 1, 1'b1);
    wait_done(3, used, seen);
    chk("t2_dbig_err", 64'(err_code), 64'd1);
    tick();
    do_start(2, HMAX + 1, 1'b1);
    wait_done(3, used, seen);
    chk("t2_nhbig_err", 64'(err_code), 64'd1);
    tick();
    chk("t2_no_kicks", 64'((n_tr - base_tr) + (gs_head.size() - base_gs)), 64'd0);

    // Causal mask, latched from the last start
    rd(1, 2, 32'hFF80_0000);
    rd(2, 1, 32'hC000_0021);
    rd(3, 3, 32'hC000_0033);
    rd(0, 3, 32'hFF80_0000);
    tick(); tick(); tick();
    chk("t3_sq_empty", 64'(sq.size()), 64'd0);

    // Watchdog on withheld gemm_done
    gemm_hold = 1'b1;
    push_writes(0, 1);
    do_start(1, 1, 1'b0);
    chk("t4_err_cleared", 64'(err_code), 64'd0);
    wait_done(TMO + 200, used, seen);
    chk("t4_done_seen", 64'(seen), 64'd1);
    chk("t4_tmo_window", 64'((cyc - gs_cyc >= TMO) && (cyc - gs_cyc <= TMO + 2)), 64'd1);
    chk("t4_err", 64'(err_code), 64'd2);
    tick();
    chk("t4_busy_low", 64'(busy), 64'd0);
    chk("t4_wq_empty", 64'(wq.size()), 64'd0);
    gemm_hold = 1'b0;

    // Abort in CP_WAIT with read data arriving the same cycle
    base_done = n_done; base_wr = n_wr;
    do_start(2, 1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tr_b_re) begin seen = 1'b1; break; end
    end
    chk("t5_read_seen", 64'(seen), 64'd1);
    tick();
    abort = 1'b1;
    #1;
    chk("t5_no_write", 64'(cpu_x_we), 64'd0);
    chk("t5_no_done", 64'(done), 64'd0);
    tick();
    abort = 1'b0;
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_err", 64'(err_code), 64'd3);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_done_count", 64'(n_done - base_done), 64'd0);
    chk("t5_write_count", 64'(n_wr - base_wr), 64'd0);

    // Reset asserted while the second head waits on GEMM
    push_writes(0, 1); push_writes(1, 1);
    base_gs = gs_head.size();
    do_start(1, 2, 1'b0);
    chk("t6_err_cleared", 64'(err_code), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gs_head.size() - base_gs >= 1) begin seen = 1'b1; break; end
    end
    tick();
    gemm_hold = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gs_head.size() - base_gs >= 2) begin seen = 1'b1; break; end
    end
    chk("t6_head1_gemm", 64'(seen), 64'd1);
    tick(); tick();
    chk("t6_head_before", 64'(head_sel), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_head", 64'(head_sel), 64'd0);
    chk("t6_rst_outs", 64'({done, tr_start, gemm_start, tr_b_re, cpu_x_we, err_code}), 64'd0);
    tick();
    rst_n = 1'b1;
    gemm_hold = 1'b0;
    tick();
    chk("t6_wq_empty", 64'(wq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
